sha256_bus_master: RTL and testbench

Hardware initiator for the SHA256 core's 8-bit-address register bus. It accepts 512-bit message blocks over a valid/ready handshake and writes the 16 block words. It then issues INIT or NEXT in SHA-256 mode, polls STATUS until ready, and on the last block reads the 8 digest words and presents a 256-bit digest. It sits between a block producer (DMA, padding unit) and the SHA256 core, so firmware does not have to drive the core's register bus itself.

---
 rtl/sha256_bus_master_if.sv | 39 +++
 rtl/sha256_bus_master.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_sha256_bus_master.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_bus_master_if.sv
`default_nettype none
// ============================================================================
// Module   : sha256_bus_master_if
// Purpose  : Register-bus bundle between the SHA256 bus master and the
//            SHA256 core (8-bit address, 32-bit data, single select).
// Signals  : cs         - bus select, driven by the master
//            we         - write enable (1 = write, 0 = read)
//            address    - core register address
//            write_data - write data (0 whenever we = 0)
//            read_data  - core read data, valid READ_LATENCY cycles after
//                         a read-issue cycle
// Modports : master (drives cs/we/address/write_data), slave (drives
//            read_data)
// Revision : 1.0 - initial release
// ============================================================================
interface sha256_bus_master_if;
  logic        cs;
  logic        we;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (
    output cs,
    output we,
    output address,
    output write_data,
    input  read_data
  );

  modport slave (
    input  cs,
    input  we,
    input  address,
    input  write_data,
    output read_data
  );
endinterface
`default_nettype wire

// File: rtl/sha256_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : sha256_bus_master
// Purpose  : Drives the SHA256 core register bus on behalf of a block
//            producer: writes the 16 words of a 512-bit block, issues INIT
//            (first block) or NEXT, polls STATUS until ready and, for the
//            last block of a message, reads the 8 digest words and presents
//            them as a 256-bit digest.
// Ports    : clk, reset_n     - clock, asynchronous active-low reset
//            blk_valid/ready  - block handshake (ready is state-only)
//            blk_data         - block, word 0 in [511:480]
//            blk_first        - block starts a message (INIT, else NEXT)
//            blk_last         - read the digest after this block
//            digest           - word 0 (addr 0x20) in [255:224]
//            digest_valid     - one-cycle pulse when digest updates
//            busy             - not idle
//            err              - STATUS poll timeout, sticky until next block
//            bus              - core register bus (master modport)
// Config   : `define SHA256_MASTER_TIMEOUT_EN builds the poll counter; a
//            block whose POLL_LIMIT-th STATUS read is still not ready sets
//            err and returns to IDLE. Undefined: polling never gives up and
//            err is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_bus_master #(
  parameter int READ_LATENCY  = 1,
  parameter int SETTLE_CYCLES = 2,
  parameter int POLL_LIMIT    = 1024
) (
  input  wire          clk,
  input  wire          reset_n,
  input  wire          blk_valid,
  output logic         blk_ready,
  input  wire  [511:0] blk_data,
  input  wire          blk_first,
  input  wire          blk_last,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         busy,
  output logic         err,
  sha256_bus_master_if.master bus
);

  localparam logic [3:0] c_s_idle      = 4'd0;
  localparam logic [3:0] c_s_wr_blk    = 4'd1;
  localparam logic [3:0] c_s_wr_ctrl   = 4'd2;
  localparam logic [3:0] c_s_settle    = 4'd3;
  localparam logic [3:0] c_s_poll_iss  = 4'd4;
  localparam logic [3:0] c_s_poll_wait = 4'd5;
  localparam logic [3:0] c_s_dig_iss   = 4'd6;
  localparam logic [3:0] c_s_dig_wait  = 4'd7;
  localparam logic [3:0] c_s_done      = 4'd8;

  localparam logic [7:0]  c_addr_ctrl   = 8'h08;
  localparam logic [7:0]  c_addr_status = 8'h09;
  localparam logic [7:0]  c_addr_block  = 8'h10;
  localparam logic [7:0]  c_addr_digest = 8'h20;
  localparam logic [31:0] c_ctrl_init   = 32'h0000_0005;  // init + SHA-256 mode
  localparam logic [31:0] c_ctrl_next   = 32'h0000_0006;  // next + SHA-256 mode

  // One shared down-time counter serves SETTLE and both read-wait states.
  localparam int c_wait_max = (READ_LATENCY > SETTLE_CYCLES) ? READ_LATENCY : SETTLE_CYCLES;
  localparam int c_wait_w   = (c_wait_max > 1) ? $clog2(c_wait_max) : 1;
  localparam logic [c_wait_w-1:0] c_lat_last    =
      c_wait_w'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
  localparam logic [c_wait_w-1:0] c_settle_last =
      c_wait_w'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  logic [3:0]          r_state;
  logic [3:0]          w_state_nxt;
  logic [3:0]          r_word;
  logic [2:0]          r_dig;
  logic [c_wait_w-1:0] r_wait;
  logic [511:0]        r_blk;
  logic                r_first;
  logic                r_last;
  logic [255:0]        r_shadow;
  logic [255:0]        r_digest;

  logic w_accept;
  logic w_lat_done;
  logic w_settle_done;
  logic w_poll_sample;
  logic w_dig_sample;
  logic w_timeout;

  assign w_accept      = (r_state == c_s_idle) && blk_valid;
  assign w_lat_done    = (r_wait == c_lat_last);
  assign w_settle_done = (r_wait == c_settle_last);

  // With zero read latency the data is already valid in the issue cycle.
  assign w_poll_sample = (READ_LATENCY == 0) ? (r_state == c_s_poll_iss)
                                             : (r_state == c_s_poll_wait) && w_lat_done;
  assign w_dig_sample  = (READ_LATENCY == 0) ? (r_state == c_s_dig_iss)
                                             : (r_state == c_s_dig_wait) && w_lat_done;

`ifdef SHA256_MASTER_TIMEOUT_EN
  localparam int c_poll_w = $clog2(POLL_LIMIT) + 1;

  logic [c_poll_w-1:0] r_poll;
  logic                r_err;

  // r_poll holds the reads already completed, so the current sample is read
  // number r_poll+1; give up when that one is the POLL_LIMIT-th and not ready.
  assign w_timeout = w_poll_sample && !bus.read_data[0] &&
                     (r_poll == c_poll_w'(POLL_LIMIT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_poll <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == c_s_wr_ctrl) begin
        r_poll <= '0;
      end else if (w_poll_sample) begin
        r_poll <= r_poll + c_poll_w'(1);
      end
      if (w_accept) begin
        r_err <= 1'b0;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  localparam int c_unused_poll_limit = POLL_LIMIT;

  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_s_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_s_idle: begin
        if (blk_valid) w_state_nxt = c_s_wr_blk;
      end
      c_s_wr_blk: begin
        if (r_word == 4'd15) w_state_nxt = c_s_wr_ctrl;
      end
      c_s_wr_ctrl: begin
        w_state_nxt = (SETTLE_CYCLES == 0) ? c_s_poll_iss : c_s_settle;
      end
      c_s_settle: begin
        if (w_settle_done) w_state_nxt = c_s_poll_iss;
      end
      c_s_poll_iss, c_s_poll_wait: begin
        if (w_poll_sample) begin
          if (bus.read_data[0]) begin
            w_state_nxt = r_last ? c_s_dig_iss : c_s_idle;
          end else if (w_timeout) begin
            w_state_nxt = c_s_idle;
          end else begin
            w_state_nxt = c_s_poll_iss;
          end
        end else if (r_state == c_s_poll_iss) begin
          w_state_nxt = c_s_poll_wait;
        end
      end
      c_s_dig_iss, c_s_dig_wait: begin
        if (w_dig_sample) begin
          w_state_nxt = (r_dig == 3'd7) ? c_s_done : c_s_dig_iss;
        end else if (r_state == c_s_dig_iss) begin
          w_state_nxt = c_s_dig_wait;
        end
      end
      c_s_done: begin
        w_state_nxt = c_s_idle;
      end
      default: begin
        w_state_nxt = c_s_idle;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs (decoded from state; blk_ready never looks at blk_valid)
  // --------------------------------------------------------------------------
  always_comb begin
    bus.cs         = 1'b0;
    bus.we         = 1'b0;
    bus.address    = 8'h00;
    bus.write_data = 32'h0;
    blk_ready      = 1'b0;
    busy           = 1'b1;
    digest_valid   = 1'b0;
    digest         = r_digest;
    case (r_state)
      c_s_idle: begin
        blk_ready = 1'b1;
        busy      = 1'b0;
      end
      c_s_wr_blk: begin
        bus.cs         = 1'b1;
        bus.we         = 1'b1;
        bus.address    = c_addr_block + {4'd0, r_word};
        bus.write_data = r_blk[511:480];
      end
      c_s_wr_ctrl: begin
        bus.cs         = 1'b1;
        bus.we         = 1'b1;
        bus.address    = c_addr_ctrl;
        bus.write_data = r_first ? c_ctrl_init : c_ctrl_next;
      end
      c_s_poll_iss: begin
        bus.cs      = 1'b1;
        bus.address = c_addr_status;
      end
      c_s_dig_iss: begin
        bus.cs      = 1'b1;
        bus.address = c_addr_digest + {5'd0, r_dig};
      end
      c_s_done: begin
        // The copy into r_digest lands at the end of this cycle; show the
        // shadow now so the pulse and the new digest coincide.
        digest_valid = 1'b1;
        digest       = r_shadow;
      end
      default: begin
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_word   <= 4'd0;
      r_dig    <= 3'd0;
      r_wait   <= '0;
      r_blk    <= '0;
      r_first  <= 1'b0;
      r_last   <= 1'b0;
      r_shadow <= '0;
      r_digest <= '0;
    end else begin
      // The block is shifted up one word per write so word k is always on top.
      if (w_accept) begin
        r_blk   <= blk_data;
        r_first <= blk_first;
        r_last  <= blk_last;
      end else if (r_state == c_s_wr_blk) begin
        r_blk <= {r_blk[479:0], 32'h0};
      end

      if (r_state == c_s_wr_blk) begin
        r_word <= r_word + 4'd1;
      end

      if (w_state_nxt != r_state) begin
        r_wait <= '0;
      end else if ((r_state == c_s_settle) || (r_state == c_s_poll_wait) ||
                   (r_state == c_s_dig_wait)) begin
        r_wait <= r_wait + c_wait_w'(1);
      end

      // Digest words arrive in address order, so shifting in from the bottom
      // leaves word 0 in [255:224] after the eighth read.
      if (w_dig_sample) begin
        r_shadow <= {r_shadow[223:0], bus.read_data};
        r_dig    <= r_dig + 3'd1;
      end

      if (r_state == c_s_done) begin
        r_digest <= r_shadow;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha256_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_bus_master
// Purpose  : Directed self-checking bench for sha256_bus_master with a small
//            register-bus model of the SHA256 core (read latency 1, STATUS
//            ready a programmable number of cycles after the CTRL write,
//            digest registers preloaded with known hash values).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_bus_master;

`ifdef SHA256_MASTER_TIMEOUT_EN
  localparam int c_poll_limit = 4;
`else
  localparam int c_poll_limit = 1024;
`endif

  localparam logic [511:0] c_abc = {32'h61626380, {14{32'h0}}, 32'h0000_0018};
  localparam logic [511:0] c_b1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] c_b2  = {{15{32'h0}}, 32'h0000_01c0};
  localparam logic [255:0] c_abc_dig =
      256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] c_nist_dig =
      256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic         tb_clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         blk_valid = 1'b0;
  logic         blk_ready;
  logic [511:0] blk_data = '0;
  logic         blk_first = 1'b0;
  logic         blk_last = 1'b0;
  logic [255:0] digest;
  logic         digest_valid;
  logic         busy;
  logic         err;

  int checks = 0;
  int failures = 0;

  sha256_bus_master_if bus ();

  sha256_bus_master #(
    .READ_LATENCY  (1),
    .SETTLE_CYCLES (2),
    .POLL_LIMIT    (c_poll_limit)
  ) dut (
    .clk          (tb_clk),
    .reset_n      (reset_n),
    .blk_valid    (blk_valid),
    .blk_ready    (blk_ready),
    .blk_data     (blk_data),
    .blk_first    (blk_first),
    .blk_last     (blk_last),
    .digest       (digest),
    .digest_valid (digest_valid),
    .busy         (busy),
    .err          (err),
    .bus          (bus)
  );

  always #5 tb_clk = ~tb_clk;

  // Core model: STATUS.ready goes high m_delay cycles after the CTRL write.
  logic [31:0] m_dig [8];
  int          m_delay = 0;
  int          m_busy = 0;
  logic [31:0] m_rdata = 32'h0;

  assign bus.read_data = m_rdata;

  always @(posedge tb_clk) begin
    if (bus.cs && bus.we && bus.address == 8'h08) m_busy <= m_delay;
    else if (m_busy != 0) m_busy <= m_busy - 1;
    if (bus.cs && !bus.we) begin
      if (bus.address == 8'h09) m_rdata <= {31'd0, m_busy == 0};
      else if (bus.address[7:3] == 5'b00100) m_rdata <= m_dig[bus.address[2:0]];
      else m_rdata <= 32'hdead_beee;
    end else begin
      m_rdata <= 32'h5a5a_5a5a;
    end
  end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic load_dig(input logic [255:0] d);
    logic [255:0] t;
    for (int i = 0; i < 8; i++) begin
      t = d >> (32 * (7 - i));
      m_dig[i] = t[31:0];
    end
  endtask

  // Handshake: returns just after the accepting edge (cycle 0).
  task automatic offer(input logic [511:0] data, input logic first, input logic last);
    @(negedge tb_clk);
    chk("blk_ready_idle", blk_ready, 1'b1);
    blk_data  = data;
    blk_first = first;
    blk_last  = last;
    blk_valid = 1'b1;
    @(posedge tb_clk);
    #1;
    blk_valid = 1'b0;
    blk_data  = '0;
    blk_first = 1'b0;
    blk_last  = 1'b0;
  endtask

  // Cycle-by-cycle check of one block from cycle 1 until the master is idle.
  task automatic check_block(input logic [511:0] data, input logic [31:0] ctrl,
                             input logic last, input int delay,
                             input logic [255:0] exp_dig, input logic [255:0] old_dig);
    int c_ready;
    int fin;
    logic [511:0] t;
    logic e_cs, e_we, e_dv;
    logic [7:0] e_addr;
    logic [31:0] e_wd;
    c_ready = (18 + delay < 20) ? 20 : 18 + delay + ((18 + delay) % 2);
    fin     = last ? c_ready + 19 : c_ready + 2;
    for (int rel = 1; rel <= fin; rel++) begin
      @(negedge tb_clk);
      e_cs = 1'b0; e_we = 1'b0; e_dv = 1'b0; e_addr = 8'h00; e_wd = 32'h0;
      if (rel <= 16) begin
        t = data >> (32 * (16 - rel));
        e_cs = 1'b1; e_we = 1'b1; e_addr = 8'h10 + 8'(rel - 1); e_wd = t[31:0];
      end else if (rel == 17) begin
        e_cs = 1'b1; e_we = 1'b1; e_addr = 8'h08; e_wd = ctrl;
      end else if (rel >= 20 && rel <= c_ready + 1) begin
        if (rel % 2 == 0) begin
          e_cs = 1'b1; e_addr = 8'h09;
        end
      end else if (last && rel >= c_ready + 2 && rel <= c_ready + 17) begin
        if ((rel - c_ready) % 2 == 0) begin
          e_cs = 1'b1; e_addr = 8'h20 + 8'((rel - c_ready - 2) / 2);
        end
      end else if (last && rel == c_ready + 18) begin
        e_dv = 1'b1;
      end
      chk($sformatf("bus_cycle%0d", rel),
          {busy, blk_ready, err, bus.cs, bus.we, bus.address, bus.write_data, digest_valid},
          {rel < fin, rel >= fin, 1'b0, e_cs, e_we, e_addr, e_wd, e_dv});
      if (last && rel == c_ready + 18) chk("digest_at_pulse", digest, exp_dig);
    end
    chk("digest_held", digest, last ? exp_dig : old_dig);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge tb_clk);
    chk("in_reset", {bus.cs, bus.we, bus.address, bus.write_data, busy, digest_valid, err},
        45'd0);
    reset_n = 1'b1;
    #1;
    chk("reset_ready", {blk_ready, busy, digest_valid, err}, 4'b1000);
    chk("reset_digest", digest, 256'd0);

    // Single-block "abc", first poll ready
    load_dig(c_abc_dig);
    m_delay = 0;
    offer(c_abc, 1'b1, 1'b1);
    check_block(c_abc, 32'h5, 1'b1, 0, c_abc_dig, 256'd0);

    // Two-block message: INIT then NEXT, digest only after the second
    load_dig(c_nist_dig);
    offer(c_b1, 1'b1, 1'b0);
    check_block(c_b1, 32'h5, 1'b0, 0, c_nist_dig, c_abc_dig);
    offer(c_b2, 1'b0, 1'b1);
    check_block(c_b2, 32'h6, 1'b1, 0, c_nist_dig, c_abc_dig);

    // Core busy for 100 cycles: only STATUS reads until ready
    load_dig(c_abc_dig);
    m_delay = 100;
    offer(c_abc, 1'b1, 1'b1);
    check_block(c_abc, 32'h5, 1'b1, 100, c_abc_dig, c_nist_dig);

    // Reset during the write of word 7
    m_delay = 0;
    offer(c_b1, 1'b1, 1'b1);
    repeat (8) @(negedge tb_clk);
    chk("mid_write_addr", bus.address, 8'h17);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", {bus.cs, bus.we, busy, digest_valid}, 4'b0000);
    chk("async_reset_digest", digest, 256'd0);
    @(negedge tb_clk);
    reset_n = 1'b1;
    #1;
    chk("post_reset_ready", {blk_ready, busy}, 2'b10);
    offer(c_abc, 1'b1, 1'b1);
    check_block(c_abc, 32'h5, 1'b1, 0, c_abc_dig, 256'd0);

`ifdef SHA256_MASTER_TIMEOUT_EN
    // Core never ready: exactly POLL_LIMIT STATUS reads, then err
    m_delay = 1000000;
    offer(c_abc, 1'b1, 1'b1);
    for (int rel = 1; rel <= 28; rel++) begin
      @(negedge tb_clk);
      if (rel >= 18)
        chk($sformatf("timeout_cycle%0d", rel), {bus.cs, bus.we, bus.address},
            (rel >= 20 && rel <= 26 && rel % 2 == 0) ? {2'b10, 8'h09} : 10'd0);
      chk($sformatf("timeout_no_dv%0d", rel), digest_valid, 1'b0);
    end
    chk("timeout_idle_err", {blk_ready, busy, err}, 3'b101);
    m_delay = 0;
    offer(c_abc, 1'b1, 1'b1);
    check_block(c_abc, 32'h5, 1'b1, 0, c_abc_dig, c_abc_dig);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
